// File: rtl/mvm_pkg.sv
// Shared types and width helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

  // Top-level controller states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_V = 3'd2,
    CALC   = 3'd3,
    DRAIN  = 3'd4,
    OUT    = 3'd5
  } state_t;

  // Accumulator width that can hold the sum of n full B x B products.
  function automatic int acc_width(input int b, input int n);
    return 2 * b + $clog2(n);
  endfunction

  // Index width for a range of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_lane.sv
// One MAC lane: holds its slice of the matrix plus a private vector copy,
// multiplies one A/x pair per cycle and emits a write strobe per finished row.
module mvm_lane
  import mvm_pkg::*;
#(
  parameter int R    = 2,
  parameter int N    = 4,
  parameter int B    = 6,
  parameter int PIPE = 0,
  parameter int AW   = acc_width(B, N),
  parameter int RW   = idx_width(R),
  parameter int CW   = idx_width(N),
  parameter int AAW  = idx_width(R * N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_we,
  input  logic [AAW-1:0]       a_addr,
  input  logic                 x_we,
  input  logic [CW-1:0]        x_addr,
  input  logic signed [B-1:0]  wdata,
  input  logic                 rd_en,
  input  logic [RW-1:0]        rd_row,
  input  logic [CW-1:0]        rd_col,
  output logic                 res_we,
  output logic [RW-1:0]        res_row,
  output logic signed [AW-1:0] res_data
);

  logic signed [B-1:0]    a_mem [R*N];
  logic signed [B-1:0]    x_mem [N];
  logic signed [B-1:0]    a_q;
  logic signed [B-1:0]    x_q;
  logic [AAW-1:0]         rd_addr;
  logic                   s1_valid;
  logic                   s1_first;
  logic                   s1_last;
  logic [RW-1:0]          s1_row;
  logic signed [2*B-1:0]  a_ext;
  logic signed [2*B-1:0]  x_ext;
  logic signed [2*B-1:0]  prod_full;
  logic signed [AW-1:0]   prod_ext;
  logic                   m_valid;
  logic                   m_first;
  logic                   m_last;
  logic [RW-1:0]          m_row;
  logic signed [AW-1:0]   m_prod;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_next;

  assign rd_addr = AAW'(int'(rd_row) * N + int'(rd_col));

  // Write ports for the matrix slice and the vector copy.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[a_addr] <= wdata;
    if (x_we) x_mem[x_addr] <= wdata;
  end

  // Registered read of the current A/x pair.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      a_q <= a_mem[rd_addr];
      x_q <= x_mem[rd_col];
    end
  end

  // Row/column tags travel alongside the read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_row   <= '0;
    end else begin
      s1_valid <= rd_en;
      s1_first <= (rd_col == '0);
      s1_last  <= (rd_col == CW'(N - 1));
      s1_row   <= rd_row;
    end
  end

  // Full-precision product, sign-extended to the accumulator width.
  assign a_ext     = {{B{a_q[B-1]}}, a_q};
  assign x_ext     = {{B{x_q[B-1]}}, x_q};
  assign prod_full = a_ext * x_ext;
  assign prod_ext  = {{(AW-2*B){prod_full[2*B-1]}}, prod_full};

  generate
    if (PIPE != 0) begin : g_pipe
      // Optional register between multiplier and adder.
      always_ff @(posedge clk) begin
        if (reset) m_valid <= 1'b0;
        else       m_valid <= s1_valid;
        m_first <= s1_first;
        m_last  <= s1_last;
        m_row   <= s1_row;
        m_prod  <= prod_ext;
      end
    end else begin : g_nopipe
      // Product feeds the adder directly.
      always_comb begin
        m_valid = s1_valid;
        m_first = s1_first;
        m_last  = s1_last;
        m_row   = s1_row;
        m_prod  = prod_ext;
      end
    end
  endgenerate

  assign acc_next = m_first ? m_prod : acc + m_prod;

  // Accumulator restarts on the first column of each row.
  always_ff @(posedge clk) begin
    if (reset)        acc <= '0;
    else if (m_valid) acc <= acc_next;
  end

  // The finished row sum is handed out in the same cycle its last term is added.
  assign res_we   = m_valid & m_last;
  assign res_row  = m_row;
  assign res_data = acc_next;

endmodule

// File: rtl/mvm_stream.sv
// Streaming y = A*x engine: command FSM, load sequencing, P MAC lanes,
// result buffer and a valid/ready output port with optional ReLU.
module mvm_stream
  import mvm_pkg::*;
#(
  parameter int M    = 4,
  parameter int N    = 4,
  parameter int P    = 1,
  parameter int B    = 6,
  parameter int PIPE = 0,
  parameter int RELU = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load_matrix,
  input  logic                               load_vector,
  input  logic                               start,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [B-1:0]                data_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [acc_width(B, N)-1:0]  data_out,
  output logic                               busy,
  output logic                               done
);

  localparam int AW  = acc_width(B, N);
  localparam int R   = M / P;
  localparam int CW  = idx_width(N);
  localparam int RW  = idx_width(R);
  localparam int LW  = idx_width(P);
  localparam int OW  = idx_width(M);
  localparam int AAW = idx_width(R * N);

  state_t               state;
  logic [CW-1:0]        ld_col;
  logic [RW-1:0]        ld_row;
  logic [LW-1:0]        ld_lane;
  logic [CW-1:0]        c_col;
  logic [RW-1:0]        c_row;
  logic                 drain_cnt;
  logic [OW-1:0]        out_idx;
  logic signed [AW-1:0] res_buf [M];
  logic                 in_fire;
  logic [AAW-1:0]       a_addr;
  logic [P-1:0]         lane_res_we;
  logic [RW-1:0]        lane_res_row  [P];
  logic signed [AW-1:0] lane_res_data [P];

  assign in_ready = (state == LOAD_M) || (state == LOAD_V);
  assign busy     = (state != IDLE);
  assign in_fire  = in_valid & in_ready;
  assign a_addr   = AAW'(int'(ld_row) * N + int'(ld_col));

  function automatic logic signed [AW-1:0] relu_fn(input logic signed [AW-1:0] v);
    if (RELU != 0 && v[AW-1]) return '0;
    return v;
  endfunction

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
      mvm_lane #(
        .R(R), .N(N), .B(B), .PIPE(PIPE),
        .AW(AW), .RW(RW), .CW(CW), .AAW(AAW)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .a_we     (in_fire && (state == LOAD_M) && (ld_lane == LW'(gi))),
        .a_addr   (a_addr),
        .x_we     (in_fire && (state == LOAD_V)),
        .x_addr   (ld_col),
        .wdata    (data_in),
        .rd_en    (state == CALC),
        .rd_row   (c_row),
        .rd_col   (c_col),
        .res_we   (lane_res_we[gi]),
        .res_row  (lane_res_row[gi]),
        .res_data (lane_res_data[gi])
      );
    end
  endgenerate

  // Collect finished rows from every lane into the result buffer.
  always_ff @(posedge clk) begin
    for (int l = 0; l < P; l++) begin
      if (lane_res_we[l]) res_buf[OW'(l * R + int'(lane_res_row[l]))] <= lane_res_data[l];
    end
  end

  // Command FSM, load/compute counters and output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ld_col    <= '0;
      ld_row    <= '0;
      ld_lane   <= '0;
      c_col     <= '0;
      c_row     <= '0;
      drain_cnt <= 1'b0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_matrix)      state <= LOAD_M;
          else if (load_vector) state <= LOAD_V;
          else if (start)       state <= CALC;
        end
        LOAD_M: begin
          if (in_fire) begin
            if (ld_col == CW'(N - 1)) begin
              ld_col <= '0;
              if (ld_row == RW'(R - 1)) begin
                ld_row <= '0;
                if (ld_lane == LW'(P - 1)) begin
                  ld_lane <= '0;
                  state   <= IDLE;
                end else begin
                  ld_lane <= ld_lane + LW'(1);
                end
              end else begin
                ld_row <= ld_row + RW'(1);
              end
            end else begin
              ld_col <= ld_col + CW'(1);
            end
          end
        end
        LOAD_V: begin
          if (in_fire) begin
            if (ld_col == CW'(N - 1)) begin
              ld_col <= '0;
              state  <= IDLE;
            end else begin
              ld_col <= ld_col + CW'(1);
            end
          end
        end
        CALC: begin
          if (c_col == CW'(N - 1)) begin
            c_col <= '0;
            if (c_row == RW'(R - 1)) begin
              c_row     <= '0;
              drain_cnt <= 1'b0;
              state     <= DRAIN;
            end else begin
              c_row <= c_row + RW'(1);
            end
          end else begin
            c_col <= c_col + CW'(1);
          end
        end
        DRAIN: begin
          // Wait out the RAM read and optional pipe stage before streaming.
          if (drain_cnt == 1'(PIPE)) state <= OUT;
          else                      drain_cnt <= 1'b1;
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            data_out  <= relu_fn(res_buf[out_idx]);
          end else if (out_ready) begin
            if (out_idx == OW'(M - 1)) begin
              out_idx   <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              out_idx  <= out_idx + OW'(1);
              data_out <= relu_fn(res_buf[out_idx + OW'(1)]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mvm_stream.md
Name: mvm_stream

Overview:
- Parametrised matrix-vector multiplier: y = A·x, A is M×N signed, x is N signed, y is M signed.
- Successor to the fixed-size k×k multiplier.
- Adds:
  - rectangular shapes;
  - P parallel lanes;
  - valid/ready streaming on both input and output with backpressure;
  - a no-overflow accumulator width;
  - an optional ReLU output mode.
- Sits between the input stream source and the result consumer.

Parameters:
- M, 4, matrix rows. Must be divisible by P.
- N, 4, matrix columns / vector length. N ≥ 2.
- P, 1, parallel MAC lanes. Lane l owns rows l·(M/P) … (l+1)·(M/P)−1.
- B, 6, input element width, signed.
- PIPE, 0, 1 inserts a register between multiplier and adder in every lane.
- RELU, 0, 1 clamps negative results to 0 at the output.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- load_matrix  in  1  command pulse: receive M·N elements, row-major
- load_vector  in  1  command pulse: receive N elements
- start  in  1  command pulse: compute and stream out y
- in_valid  in  1  data_in valid
- in_ready  out  1  block accepts data_in
- data_in  in  B  signed element
- out_valid  out  1  data_out valid
- out_ready  in  1  consumer accepts data_out
- data_out  out  AW  signed result, AW = 2B + clog2(N)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset values: state IDLE; all counters 0; in_ready, out_valid, busy and done 0; data_out 0. Memory contents are not reset.
- States:
  - IDLE → LOAD_M on load_matrix.
  - IDLE → LOAD_V on load_vector.
  - IDLE → CALC on start.
  - Command priority when several are high at once: load_matrix > load_vector > start.
  - Commands are ignored outside IDLE.
- Loading (LOAD_M / LOAD_V):
  - in_ready = 1 in these states.
  - An element transfers only on in_valid & in_ready. Gaps in in_valid are legal.
  - Matrix element (r,c) is written to lane r/(M/P) at address (r mod (M/P))·N + c.
  - Vector element c is written to every lane's vector buffer at address c.
  - The state returns to IDLE on the cycle after the final transfer.
  - in_ready is 0 in all other states.
- CALC:
  - Lasts exactly C = (M/P)·N cycles.
  - Each lane reads one A/x pair per cycle, row-major within its rows.
  - The accumulator clears at the first column of each row.
  - The result is written to the result buffer index r when the last column has passed the MAC.
  - Arithmetic is full precision: the B×B product is sign-extended to AW, and no overflow is possible.
- DRAIN:
  - Lasts 1 + PIPE cycles: memory read latency plus the optional pipe stage.
  - Then the state moves to OUT.
  - Timing: start is sampled at edge T. out_valid first rises at edge T + C + 2 + PIPE.
- OUT:
  - Results stream in row order 0 … M−1.
  - A result advances only on out_valid & out_ready.
  - While out_ready = 0, data_out and out_valid hold stable.
  - RELU = 1: a negative result is output as 0.
  - After the M-th transfer: done pulses 1 cycle, out_valid drops, and the state returns to IDLE.
- Reuse: the matrix and vector persist, so repeated start commands recompute without reloading. Reloading the vector alone is legal.
- start without prior loads: the result is undefined, but the handshake and timing are unchanged.
- Reset mid-operation: the block returns to the reset values on the next edge. Partial loads leave memory partially overwritten.

Decomposition:
- Package mvm_pkg:
  - state enum {IDLE, LOAD_M, LOAD_V, CALC, DRAIN, OUT};
  - function acc_width(B, N).
- One sub-module, mvm_lane, per lane:
  - matrix RAM of (M/P)·N × B;
  - vector RAM of N × B;
  - MAC with the optional PIPE stage;
  - accumulator clear and result-write strobe.
- The top level holds the FSM, the load counters, the result buffer and the output handshake.

Test Plan:
- M=N=4, P=2, B=6: load identity, load x = [1,−2,3,−4], start → outputs 1, −2, 3, −4; done pulses once.
- Same data with RELU=1 → outputs 1, 0, 3, 0.
- All A = −32, x = −32 → each output 4096 (AW = 14); no wrap.
- Backpressure: hold out_ready = 0 for 3 cycles after the first out_valid → data_out stays 1, no result lost or duplicated. Random in_valid gaps during loads → same results.
- Latency: P=1 and P=4 with PIPE 0/1 → first out_valid at T+18, T+19, T+6, T+7.
- Assert reset mid-CALC, then reload, then start → correct results. A start issued during LOAD_M is ignored, and busy stays 1.
